// File: rtl/otter_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the otter_bus secondary side.
// Bytes are queued in a TX FIFO and shifted out LSB first on tx.
module otter_uart_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 868,
  parameter int WIDTH       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             rd,
  input  logic [1:0]       size,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             error,
  output logic             tx,
  output logic             irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [15:0]     baud_cnt_q, baud_cnt_d;
  logic [15:0]     div_q, div_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic [3:0]      a_s;
  logic            full_s, empty_s, pop_s, push_s, div_wr_s, error_s, tx_s;
  logic [15:0]     p_m1_s;
  logic [7:0]      cnt8_s;
  logic [WIDTH-1:0] rdata_s;
  logic            unused_bits;

  assign a_s     = addr[3:0];
  assign full_s  = (count_q == CW'(FIFO_DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});
  assign pop_s   = (state_q == IDLE) && !empty_s;
  assign p_m1_s  = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);
  assign cnt8_s  = 8'(count_q);
  assign unused_bits = ^{addr[WIDTH-1:4], wdata[WIDTH-1:16]};

  // A full FIFO still accepts a push when the transmitter pops in the same cycle.
  assign error_s = (wr || rd) && (
                     (a_s[1:0] != 2'b00) || (a_s == 4'hC) ||
                     (size == 2'b11) || (size == 2'b01) ||
                     ((size == 2'b00) && (a_s != 4'h0)) ||
                     (wr && rd) || (wr && (a_s == 4'h4)) ||
                     (wr && (a_s == 4'h0) && full_s && !pop_s));

  assign push_s   = wr && !error_s && (a_s == 4'h0);
  assign div_wr_s = wr && !error_s && (a_s == 4'h8);

  // Register read mux; silent unless a legal read is in progress.
  always_comb begin
    rdata_s = {WIDTH{1'b0}};
    if (rd && !error_s) begin
      case (a_s)
        4'h4: begin
          rdata_s[0]    = (state_q != IDLE);
          rdata_s[1]    = full_s;
          rdata_s[2]    = empty_s;
          rdata_s[15:8] = cnt8_s;
        end
        4'h8:    rdata_s[15:0] = div_q;
        default: rdata_s = {WIDTH{1'b0}};
      endcase
    end else begin
      rdata_s = {WIDTH{1'b0}};
    end
  end

  // FIFO pointer/count and baud divider next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    div_d   = div_q;
    if (push_s) begin
      wptr_d = wptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    if (div_wr_s) begin
      div_d = wdata[15:0];
    end else begin
      div_d = div_q;
    end
  end

  // Transmit FSM; the baud counter reloads from the live divider at each bit boundary.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = baud_cnt_q;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          shift_d    = mem_q[rptr_q];
          baud_cnt_d = p_m1_s;
          bit_idx_d  = 3'd0;
          state_d    = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_cnt_q == 16'd0) begin
          baud_cnt_d = p_m1_s;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_cnt_q == 16'd0) begin
          baud_cnt_d = p_m1_s;
          shift_d    = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_cnt_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows state so an async reset raises tx without a clock.
  always_comb begin
    case (state_q)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_q[0];
      default: tx_s = 1'b1;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= 8'd0;
      bit_idx_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      div_q      <= 16'(DEFAULT_DIV);
      wptr_q     <= {AW{1'b0}};
      rptr_q     <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are only observable through the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= wdata[7:0];
    end
  end

  assign rdata = rdata_s;
  assign error = error_s;
  assign tx    = tx_s;
  assign irq   = empty_s && (state_q == IDLE);

endmodule

// File: tb/tb_otter_uart_tx.sv
// Directed bench for otter_uart_tx: bus accesses plus a cycle-exact serial
// receiver that checks frames against a queue of expected bytes.
module tb_otter_uart_tx;

  logic        clk, rst_n, wr, rd, error, tx, irq;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  int p4 [10];
  int pmid [10];

  otter_uart_tx #(.FIFO_DEPTH(16), .DEFAULT_DIV(868), .WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .error(error), .tx(tx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample combinational outputs, commit at posedge.
  task automatic bus(input logic w, input logic r, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic e, output logic [31:0] rdo);
    @(negedge clk);
    wr = w; rd = r; size = sz; addr = a; wdata = d;
    #1;
    e = error; rdo = rdata;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  // Receive one frame cycle by cycle; plen gives each bit's length in cycles.
  task automatic recv_frame(input int plen [10], input int mid_cyc,
                            input logic [15:0] mid_div, input int exp_idle);
    int waited, mism, c;
    logic [7:0] eb, rxb;
    logic lvl;
    waited = 0; mism = 0; c = 0; rxb = 8'h00;
    @(negedge clk);
    while (tx !== 1'b0 && waited < 2000) begin
      waited++;
      @(negedge clk);
    end
    if (tx !== 1'b0) begin
      chk("frame_start", {31'd0, tx}, 32'd0);
      return;
    end
    if (exp_idle >= 0) chk("idle_gap", 32'(waited), 32'(exp_idle));
    if (exp_q.size() == 0) begin
      chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
      return;
    end
    eb = exp_q.pop_front();
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < plen[k]; j++) begin
        if (k == 0) lvl = 1'b0;
        else if (k == 9) lvl = 1'b1;
        else lvl = eb[k-1];
        if (tx !== lvl) mism++;
        if (irq !== 1'b0) mism++;
        if (k >= 1 && k <= 8 && j == plen[k] / 2) rxb[k-1] = tx;
        if (c == mid_cyc) begin
          wr = 1'b1; rd = 1'b0; size = 2'b10; addr = 32'h8; wdata = {16'd0, mid_div};
        end else begin
          wr = 1'b0;
        end
        c++;
        if (!(k == 9 && j == plen[k] - 1)) @(negedge clk);
      end
    end
    chk("frame_data", {24'd0, rxb}, {24'd0, eb});
    chk("frame_timing_mism", 32'(mism), 32'd0);
  endtask

  initial begin
    logic e;
    logic [31:0] r;
    int lowc;
    p4   = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    pmid = '{4, 4, 4, 4, 4, 8, 8, 8, 8, 8};
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0;
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    bus(1'b0, 1'b1, 2'b10, 32'h8, 32'h0, e, r);
    chk("rd_div_err", {31'd0, e}, 32'd0);
    chk("rd_div_reset", r, 32'd868);
    bus(1'b0, 1'b1, 2'b10, 32'h4, 32'h0, e, r);
    chk("rd_status_reset", r, 32'h0000_0004);

    // Single frame at P=4.
    bus(1'b1, 1'b0, 2'b10, 32'h8, 32'd4, e, r);
    chk("wr_div_err", {31'd0, e}, 32'd0);
    bus(1'b1, 1'b0, 2'b00, 32'h0, 32'h55, e, r);
    chk("wr_55_err", {31'd0, e}, 32'd0);
    exp_q.push_back(8'h55);
    recv_frame(p4, -1, 16'd0, 1);
    @(negedge clk);
    chk("irq_after_frame", {31'd0, irq}, 32'd1);
    chk("tx_after_frame", {31'd0, tx}, 32'd1);

    // Burst: the first pop frees a slot, so 17 bytes fit and the 18th overflows.
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          bus(1'b1, 1'b0, 2'b10, 32'h0, 32'(8'h11 + 8'(i * 13)), e, r);
          chk("burst_wr_err", {31'd0, e}, 32'd0);
          exp_q.push_back(8'h11 + 8'(i * 13));
        end
        bus(1'b1, 1'b0, 2'b10, 32'h0, 32'hEE, e, r);
        chk("burst_overflow_err", {31'd0, e}, 32'd1);
        bus(1'b0, 1'b1, 2'b10, 32'h4, 32'h0, e, r);
        chk("burst_status_full", r, 32'h0000_1003);
      end
      begin
        for (int i = 0; i < 17; i++) recv_frame(p4, -1, 16'd0, (i == 0) ? -1 : 1);
      end
    join
    chk("burst_sb_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    // Illegal accesses leave the FIFO and divider untouched.
    bus(1'b1, 1'b0, 2'b01, 32'h0, 32'hAA, e, r);
    chk("ill_half_wr", {31'd0, e}, 32'd1);
    bus(1'b0, 1'b1, 2'b10, 32'hC, 32'h0, e, r);
    chk("ill_rd_c", {31'd0, e}, 32'd1);
    chk("ill_rd_c_rdata", r, 32'd0);
    bus(1'b1, 1'b0, 2'b10, 32'h4, 32'hFFFF_FFFF, e, r);
    chk("ill_wr_status", {31'd0, e}, 32'd1);
    bus(1'b0, 1'b1, 2'b10, 32'h2, 32'h0, e, r);
    chk("ill_misalign", {31'd0, e}, 32'd1);
    bus(1'b1, 1'b1, 2'b10, 32'h8, 32'd99, e, r);
    chk("ill_wr_rd", {31'd0, e}, 32'd1);
    chk("ill_wr_rd_rdata", r, 32'd0);
    bus(1'b1, 1'b0, 2'b00, 32'h8, 32'd77, e, r);
    chk("ill_byte_div", {31'd0, e}, 32'd1);
    bus(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, e, r);
    chk("rd_txdata_err", {31'd0, e}, 32'd0);
    chk("rd_txdata_val", r, 32'd0);
    bus(1'b0, 1'b1, 2'b10, 32'h4, 32'h0, e, r);
    chk("ill_status_after", r, 32'h0000_0004);
    bus(1'b0, 1'b1, 2'b10, 32'h8, 32'h0, e, r);
    chk("ill_div_after", r, 32'd4);

    // Divider change during data bit 3 takes effect from bit 4.
    bus(1'b1, 1'b0, 2'b10, 32'h0, 32'hC3, e, r);
    exp_q.push_back(8'hC3);
    recv_frame(pmid, 17, 16'd8, 1);
    bus(1'b0, 1'b1, 2'b10, 32'h8, 32'h0, e, r);
    chk("mid_div_val", r, 32'd8);

    // Reset during data bit 5 (0x0F has bit 5 low).
    bus(1'b1, 1'b0, 2'b10, 32'h8, 32'd4, e, r);
    bus(1'b1, 1'b0, 2'b10, 32'h0, 32'h0F, e, r);
    bus(1'b1, 1'b0, 2'b10, 32'h0, 32'h3C, e, r);
    lowc = 0;
    @(negedge clk);
    while (tx !== 1'b0 && lowc < 200) begin
      lowc++;
      @(negedge clk);
    end
    chk("rst_frame_started", {31'd0, tx}, 32'd0);
    repeat (25) @(negedge clk);
    chk("pre_reset_tx", {31'd0, tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx", {31'd0, tx}, 32'd1);
    chk("async_reset_irq", {31'd0, irq}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus(1'b0, 1'b1, 2'b10, 32'h4, 32'h0, e, r);
    chk("post_reset_status", r, 32'h0000_0004);
    bus(1'b0, 1'b1, 2'b10, 32'h8, 32'h0, e, r);
    chk("post_reset_div", r, 32'd868);
    lowc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lowc++;
    end
    chk("post_reset_tx_idle", 32'(lowc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
